// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   sb_entry_t     : one posted store {word index, data, byte strobes}
//   merge_bytes    : overlay the strobed bytes of new_word onto old_word
//   addr_in_range  : true when addr falls inside [base, base + size_bytes)
package dmem_pkg;

    // Widest word index a 32-bit byte address can produce; narrower arrays
    // zero-extend into this field.
    localparam int unsigned IdxMaxW = 30;

    typedef logic [IdxMaxW-1:0] word_idx_t;

    typedef struct packed {
        word_idx_t   idx;
        logic [31:0] data;
        logic [3:0]  strb;
    } sb_entry_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // 33-bit arithmetic so a window ending exactly at 2^32 still works.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] size_bytes);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < size_bytes);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage store/load bus between the pipeline (master) and the data
// memory responder (slave).
//   store: mem_we, mem_wb_addr, mem_wb_data, mem_wb_strb -> mem_wr_ready
//   load : mem_re, mem_rd_addr -> mem_rd_ready, mem_rd_valid, mem_rd_data
//   mem_err: one-cycle pulse for an accepted out-of-range request
interface dmem_responder_if;

    logic        mem_we;
    logic [31:0] mem_wb_addr;
    logic [31:0] mem_wb_data;
    logic [3:0]  mem_wb_strb;
    logic        mem_wr_ready;

    logic        mem_re;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ready;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        mem_err;

    modport master (
        output mem_we, mem_wb_addr, mem_wb_data, mem_wb_strb,
        output mem_re, mem_rd_addr,
        input  mem_wr_ready, mem_rd_ready, mem_rd_valid, mem_rd_data, mem_err
    );

    modport slave (
        input  mem_we, mem_wb_addr, mem_wb_data, mem_wb_strb,
        input  mem_re, mem_rd_addr,
        output mem_wr_ready, mem_rd_ready, mem_rd_valid, mem_rd_data, mem_err
    );

endinterface

// File: rtl/dmem_store_buf.sv
// In-order posted store buffer (FIFO of sb_entry_t).
//   clk, rst       : clock, asynchronous active-high reset
//   push_i         : enqueue push_entry_i (ignored when full)
//   pop_i          : dequeue the head (ignored when empty)
//   full_o/empty_o : occupancy flags
//   count_o        : number of valid entries
//   entries_o      : all slots in age order, [0] is the head (oldest)
//   valid_o        : valid_o[i] set when entries_o[i] holds a live store
module dmem_store_buf
    import dmem_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  sb_entry_t                push_entry_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o,
    output sb_entry_t                entries_o [Depth],
    output logic [Depth-1:0]         valid_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    sb_entry_t         mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; valid_o masks stale slots.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Rotate physical slots into age order; pointer wrap is free because
    // Depth is a power of two.
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            entries_o[i] = mem_q[rd_ptr_q + PtrW'(i)];
            valid_o[i]   = (CntW'(i) < count_q);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serves byte-strobed stores and word loads from a
// single-port word array. Stores are posted through dmem_store_buf; loads
// forward byte-wise from every older buffered store to the same word.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dmem_responder_if.slave (store, load and error signals)
// Parameters: DEPTH_WORDS (array words, power of two), SB_DEPTH (store
// buffer entries, power of two >= 2), BASE_ADDR (byte address of word 0).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned SB_DEPTH    = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);

    localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
    localparam int unsigned CntW      = $clog2(SB_DEPTH) + 1;
    localparam logic [32:0] SizeBytes = 33'(DEPTH_WORDS) * 33'd4;

    // Address decode
    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] rd_idx;
    logic            wr_in_range;
    logic            rd_in_range;

    assign wr_idx      = IdxW'((bus.mem_wb_addr - BASE_ADDR) >> 2);
    assign rd_idx      = IdxW'((bus.mem_rd_addr - BASE_ADDR) >> 2);
    assign wr_in_range = addr_in_range(bus.mem_wb_addr, BASE_ADDR, SizeBytes);
    assign rd_in_range = addr_in_range(bus.mem_rd_addr, BASE_ADDR, SizeBytes);

    // Store buffer
    logic              sb_push;
    logic              sb_pop;
    logic              sb_full;
    logic              sb_empty;
    logic [CntW-1:0]   sb_count;
    sb_entry_t         sb_push_entry;
    sb_entry_t         sb_entries [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_valid;

    dmem_store_buf #(
        .Depth (SB_DEPTH)
    ) u_store_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (sb_push),
        .push_entry_i (sb_push_entry),
        .pop_i        (sb_pop),
        .full_o       (sb_full),
        .empty_o      (sb_empty),
        .count_o      (sb_count),
        .entries_o    (sb_entries),
        .valid_o      (sb_valid)
    );

    // Handshakes and array-port arbitration
    logic wr_ready;
    logic rd_ready;
    logic wr_accept;
    logic rd_accept;
    logic drain;

    // Registered state only: no path from mem_we to mem_wr_ready.
    assign wr_ready = (sb_count < CntW'(SB_DEPTH));

    // A full buffer takes the port from a waiting load so stores always drain;
    // otherwise a load owns the port and stores drain only on idle cycles.
    always_comb begin
        rd_ready = 1'b1;
        drain    = 1'b0;
        if (sb_full && bus.mem_re) begin
            rd_ready = 1'b0;
            drain    = 1'b1;
        end else if (bus.mem_re) begin
            drain    = 1'b0;
        end else if (!sb_empty) begin
            drain    = 1'b1;
        end
    end

    assign wr_accept = bus.mem_we && wr_ready;
    assign rd_accept = bus.mem_re && rd_ready;

    // Out-of-range stores are acknowledged but never buffered.
    assign sb_push = wr_accept && wr_in_range;
    assign sb_pop  = drain;

    always_comb begin
        sb_push_entry      = '0;
        sb_push_entry.idx  = word_idx_t'(wr_idx);
        sb_push_entry.data = bus.mem_wb_data;
        sb_push_entry.strb = bus.mem_wb_strb;
    end

    // Forwarding: walk oldest to youngest so younger bytes win. Only entries
    // already present are seen; a store pushed this cycle is ordered after.
    logic [31:0] fwd_data;
    logic [3:0]  fwd_strb;

    always_comb begin
        fwd_data = '0;
        fwd_strb = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid[i] && (sb_entries[i].idx == word_idx_t'(rd_idx))) begin
                fwd_data = merge_bytes(fwd_data, sb_entries[i].data, sb_entries[i].strb);
                fwd_strb = fwd_strb | sb_entries[i].strb;
            end
        end
    end

    // Word array
    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [IdxW-1:0] head_idx;
    logic [31:0]     arr_rd_q;

    assign head_idx = sb_entries[0].idx[IdxW-1:0];

    always_ff @(posedge clk) begin
        if (drain) begin
            for (int b = 0; b < 4; b++) begin
                if (sb_entries[0].strb[b]) begin
                    mem_q[head_idx][8*b +: 8] <= sb_entries[0].data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_rd_q <= '0;
        end else if (rd_accept && rd_in_range) begin
            arr_rd_q <= mem_q[rd_idx];
        end
    end

    // Load response registers; forwarded bytes are merged one cycle later
    // with the array word, and everything holds until the next load.
    logic        rd_valid_q;
    logic        err_q;
    logic        rd_oor_q;
    logic [31:0] fwd_data_q;
    logic [3:0]  fwd_strb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_oor_q   <= 1'b0;
            fwd_data_q <= '0;
            fwd_strb_q <= '0;
        end else begin
            rd_valid_q <= rd_accept;
            err_q      <= (rd_accept && !rd_in_range) || (wr_accept && !wr_in_range);
            if (rd_accept) begin
                rd_oor_q   <= !rd_in_range;
                fwd_data_q <= fwd_data;
                fwd_strb_q <= fwd_strb;
            end
        end
    end

    assign bus.mem_wr_ready = wr_ready;
    assign bus.mem_rd_ready = rd_ready;
    assign bus.mem_rd_valid = rd_valid_q;
    assign bus.mem_err      = err_q;
    assign bus.mem_rd_data  = rd_oor_q ? 32'h0 : merge_bytes(arr_rd_q, fwd_data_q, fwd_strb_q);

endmodule
